// File: rtl/operand_sequencer.sv
// Operand sequencer: buffers 3-bit samples in a 4-deep FIFO, gathers them into
// three operand registers and steps the datapath through load/feedback frames.
module operand_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [2:0] in_data,
    output logic       in_ready,
    input  logic       cfg_we,
    input  logic [2:0] cfg_a1,
    input  logic [2:0] cfg_a2,
    input  logic [2:0] cfg_iter,
    output logic [2:0] x1,
    output logic [2:0] x2,
    output logic [2:0] x3,
    output logic [2:0] a1,
    output logic [2:0] a2,
    output logic       ant,
    output logic       frame_start,
    output logic       frame_done,
    output logic       busy
);
    localparam int unsigned DW    = 3;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PW    = 2;
    localparam int unsigned CW    = 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        LOAD    = 3'd2,
        RUN     = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t        state, state_n;
    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [1:0]    idx;
    logic [CW-1:0] counter;
    logic [DW-1:0] stg_a1, stg_a2, stg_iter, act_iter;
    logic          push_c, pop_c, empty_c, full_c;

    // Full blocks a push even when a pop happens in the same cycle.
    assign full_c   = (count == CW'(DEPTH));
    assign empty_c  = (count == '0);
    assign in_ready = !full_c;
    assign push_c   = in_valid && !full_c;

    // Next-state and pop decode
    always_comb begin
        state_n = state;
        pop_c   = 1'b0;
        case (state)
            IDLE:    if (!empty_c) state_n = COLLECT;
            COLLECT: begin
                if (!empty_c) begin
                    pop_c = 1'b1;
                    if (idx == 2'd2) state_n = LOAD;
                end
            end
            LOAD:    state_n = (act_iter == '0) ? DONE : RUN;
            RUN:     if (counter == CW'(1)) state_n = DONE;
            DONE:    state_n = empty_c ? IDLE : COLLECT;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // FIFO storage carries no reset; validity is tracked by count
    always_ff @(posedge clk) begin
        if (push_c) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PW'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
            case ({push_c, pop_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Operand capture, config staging/activation and feedback counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx      <= '0;
            x1       <= '0;
            x2       <= '0;
            x3       <= '0;
            stg_a1   <= '0;
            stg_a2   <= '0;
            stg_iter <= '0;
            a1       <= '0;
            a2       <= '0;
            act_iter <= '0;
            counter  <= '0;
        end else begin
            if (cfg_we) begin
                stg_a1   <= cfg_a1;
                stg_a2   <= cfg_a2;
                stg_iter <= cfg_iter;
            end
            if (pop_c) begin
                case (idx)
                    2'd0:    x1 <= mem[rd_ptr];
                    2'd1:    x2 <= mem[rd_ptr];
                    default: x3 <= mem[rd_ptr];
                endcase
                idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            end
            if (state == COLLECT && state_n == LOAD) begin
                a1       <= stg_a1;
                a2       <= stg_a2;
                act_iter <= stg_iter;
            end
            if (state == LOAD)     counter <= act_iter;
            else if (state == RUN) counter <= counter - CW'(1);
        end
    end

    // Status flops are loaded from the next state so they align with the state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ant         <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            ant         <= (state_n == RUN);
            frame_start <= (state_n == LOAD);
            frame_done  <= (state_n == DONE);
            busy        <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_operand_sequencer.sv
// Self-checking bench for operand_sequencer: vector table of frames, a frame
// scoreboard checked on frame_start/frame_done, and hand-built reset/backpressure cases.
module tb_operand_sequencer;
    logic       clk, reset;
    logic       in_valid, in_ready, cfg_we;
    logic [2:0] in_data, cfg_a1, cfg_a2, cfg_iter;
    logic [2:0] x1, x2, x3, a1, a2;
    logic       ant, frame_start, frame_done, busy;

    operand_sequencer dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .cfg_we(cfg_we), .cfg_a1(cfg_a1), .cfg_a2(cfg_a2), .cfg_iter(cfg_iter),
        .x1(x1), .x2(x2), .x3(x3), .a1(a1), .a2(a2),
        .ant(ant), .frame_start(frame_start), .frame_done(frame_done), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] cfg_a1, cfg_a2, cfg_iter;
        logic [2:0] d0, d1, d2;
        logic [2:0] exp_x1, exp_x2, exp_x3, exp_a1, exp_a2;
        int         exp_run;
    } vec_t;

    vec_t exp_q[$];
    vec_t cur;
    vec_t tbl[4];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_done  = 0;
    bit   active  = 0;
    int   gap, ant_cnt, w, done_before;

    function automatic vec_t mk(input logic [2:0] ca1, ca2, cit, d0, d1, d2,
                                input logic [2:0] ex1, ex2, ex3, ea1, ea2,
                                input int erun);
        vec_t v;
        v.cfg_a1 = ca1; v.cfg_a2 = ca2; v.cfg_iter = cit;
        v.d0 = d0; v.d1 = d1; v.d2 = d2;
        v.exp_x1 = ex1; v.exp_x2 = ex2; v.exp_x3 = ex3;
        v.exp_a1 = ea1; v.exp_a2 = ea2; v.exp_run = erun;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame monitor: pops the expected frame at frame_start, checks timing at frame_done
    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            active = 0;
        end else begin
            if (frame_start && frame_done) chk("start_done_overlap", 1, 0);
            if (active) begin
                gap++;
                if (ant) ant_cnt++;
            end
            if (frame_done) begin
                n_done++;
                chk("done_in_frame", int'(active), 1);
                if (active) begin
                    chk("run_len", ant_cnt, cur.exp_run);
                    chk("done_gap", gap, cur.exp_run + 1);
                    chk("done_ant", int'(ant), 0);
                    chk("x1_hold", int'(x1), int'(cur.exp_x1));
                    chk("a1_hold", int'(a1), int'(cur.exp_a1));
                end
                active = 0;
            end
            if (frame_start) begin
                chk("start_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                    chk("load_x1", int'(x1), int'(cur.exp_x1));
                    chk("load_x2", int'(x2), int'(cur.exp_x2));
                    chk("load_x3", int'(x3), int'(cur.exp_x3));
                    chk("load_a1", int'(a1), int'(cur.exp_a1));
                    chk("load_a2", int'(a2), int'(cur.exp_a2));
                    chk("load_ant", int'(ant), 0);
                    active  = 1;
                    gap     = 0;
                    ant_cnt = 0;
                end
            end
        end
    end

    task automatic write_cfg(input logic [2:0] va1, va2, vit);
        cfg_we = 1'b1; cfg_a1 = va1; cfg_a2 = va2; cfg_iter = vit;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic push(input logic [2:0] d, output int waited);
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && waited < 40) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) chk("push_timeout", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_ant();
        int n = 0;
        while (!ant && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_run", int'(ant), 1);
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while ((busy || active || exp_q.size() != 0) && n < max_cycles) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_idle", int'(busy || active || exp_q.size() != 0), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_ant"}, int'(ant), 0);
        chk({tag, "_x"}, int'({x1, x2, x3}), 0);
        chk({tag, "_a"}, int'({a1, a2}), 0);
        chk({tag, "_pulses"}, int'({frame_start, frame_done}), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = mk(3'd2, 3'd3, 3'd2, 3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd3, 3'd2, 3'd3, 2);
        tbl[1] = mk(3'd1, 3'd7, 3'd0, 3'd4, 3'd5, 3'd6, 3'd4, 3'd5, 3'd6, 3'd1, 3'd7, 0);
        tbl[2] = mk(3'd7, 3'd1, 3'd3, 3'd7, 3'd0, 3'd5, 3'd7, 3'd0, 3'd5, 3'd7, 3'd1, 3);
        tbl[3] = mk(3'd4, 3'd6, 3'd1, 3'd2, 3'd4, 3'd6, 3'd2, 3'd4, 3'd6, 3'd4, 3'd6, 1);

        reset = 1'b0; in_valid = 1'b0; in_data = '0;
        cfg_we = 1'b0; cfg_a1 = '0; cfg_a2 = '0; cfg_iter = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("por");
        reset = 1'b1;
        @(posedge clk); #1;

        // Table-driven frames
        for (int i = 0; i < 4; i++) begin
            write_cfg(tbl[i].cfg_a1, tbl[i].cfg_a2, tbl[i].cfg_iter);
            exp_q.push_back(tbl[i]);
            push(tbl[i].d0, w);
            push(tbl[i].d1, w);
            push(tbl[i].d2, w);
            wait_idle(80);
            chk("idle_busy", int'(busy), 0);
        end

        // Backpressure: fill during a long RUN, 5th sample held until next COLLECT
        write_cfg(3'd2, 3'd5, 3'd7);
        exp_q.push_back(mk(3'd2, 3'd5, 3'd7, 3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd3, 3'd2, 3'd5, 7));
        exp_q.push_back(mk(3'd2, 3'd5, 3'd7, 3'd4, 3'd5, 3'd6, 3'd4, 3'd5, 3'd6, 3'd2, 3'd5, 7));
        exp_q.push_back(mk(3'd2, 3'd5, 3'd7, 3'd7, 3'd0, 3'd1, 3'd7, 3'd0, 3'd1, 3'd2, 3'd5, 7));
        push(3'd1, w); push(3'd2, w); push(3'd3, w);
        wait_ant();
        push(3'd4, w); push(3'd5, w); push(3'd6, w); push(3'd7, w);
        chk("full_in_ready", int'(in_ready), 0);
        chk("full_still_run", int'(ant), 1);
        push(3'd0, w);
        chk("held_stalled", int'(w > 0), 1);
        push(3'd1, w);
        wait_idle(200);

        // Mid-frame config write applies only to the following frame
        write_cfg(3'd2, 3'd3, 3'd3);
        exp_q.push_back(mk(3'd2, 3'd3, 3'd3, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3));
        push(3'd1, w); push(3'd1, w); push(3'd1, w);
        wait_ant();
        write_cfg(3'd5, 3'd3, 3'd1);
        wait_idle(80);
        exp_q.push_back(mk(3'd5, 3'd3, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd5, 3'd3, 1));
        push(3'd2, w); push(3'd2, w); push(3'd2, w);
        wait_idle(80);

        // Reset in RUN with a full FIFO, then push on the first edge after release
        write_cfg(3'd1, 3'd1, 3'd7);
        exp_q.push_back(mk(3'd1, 3'd1, 3'd7, 3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd3, 3'd1, 3'd1, 7));
        push(3'd1, w); push(3'd2, w); push(3'd3, w);
        wait_ant();
        push(3'd4, w); push(3'd5, w); push(3'd6, w); push(3'd7, w);
        chk("rst_full_in_ready", int'(in_ready), 0);
        #2 reset = 1'b0;
        #1;
        chk_reset_outputs("rst_run_full");
        exp_q.delete();
        @(posedge clk); #3;
        reset = 1'b1;
        exp_q.push_back(mk(3'd0, 3'd0, 3'd0, 3'd6, 3'd5, 3'd4, 3'd6, 3'd5, 3'd4, 3'd0, 3'd0, 0));
        push(3'd6, w);
        chk("first_edge_push", w, 0);
        push(3'd5, w); push(3'd4, w);
        wait_idle(80);

        // Reset in the 2nd RUN cycle with 2 samples queued: no completion afterwards
        write_cfg(3'd3, 3'd3, 3'd7);
        exp_q.push_back(mk(3'd3, 3'd3, 3'd7, 3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 7));
        push(3'd1, w); push(3'd2, w); push(3'd3, w); push(3'd4, w); push(3'd5, w);
        wait_ant();
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        chk_reset_outputs("rst_run2");
        done_before = n_done;
        exp_q.delete();
        @(posedge clk); #3;
        reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_in_ready", int'(in_ready), 1);
        chk("post_rst_no_done", n_done, done_before);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
